// File: rtl/btb_predictor.sv
// btb_predictor
//   Fetch-stage branch predictor: a direct-mapped BTB whose entries each hold
//   a valid bit, tag, word target and a 2-bit saturating direction counter.
//   Lookup is combinational on the fetch PC. EXE-stage resolutions train the
//   table at the clock edge. Two 32-bit event counters support perf monitoring.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   if_vld, if_pc       fetch PC and its valid
//   pred_taken          lookup hit with counter in a taken state
//   pred_next_pc        predicted next fetch PC (target or PC+4)
//   upd_vld, upd_pc     resolved B-type branch and its PC
//   upd_taken           actual outcome
//   upd_target          resolved taken target
//   upd_mispred         EXE flush for this branch (qualified by upd_vld)
//   br_cnt              resolved-branch count
//   mispred_cnt         mispredicted-branch count
module btb_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_vld,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_vld,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int NENT  = 1 << IDX_W;

    logic [NENT-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [NENT];
    logic [TAG_W-1:0] tag_d [NENT];
    logic [29:0]      tgt_q [NENT];
    logic [29:0]      tgt_d [NENT];
    logic [1:0]       ctr_q [NENT];
    logic [1:0]       ctr_d [NENT];
    logic [31:0]      br_cnt_q, br_cnt_d;
    logic [31:0]      mis_cnt_q, mis_cnt_d;

    // Low address bits are architecturally zero; fold them here so lint sees them used.
    logic unused_lsbs;
    assign unused_lsbs = ^{upd_target[1:0], if_pc[1:0]};

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic [29:0]      l_seq;

    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[31:IDX_W+2];
    // rst gates the hit so outputs fall back immediately, even mid-cycle.
    assign l_hit = !rst && if_vld && valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_seq = if_pc[31:2] + 30'd1;   // word increment wraps modulo 2^32

    assign pred_taken   = l_hit && ctr_q[l_idx][1];
    assign pred_next_pc = pred_taken ? {tgt_q[l_idx], 2'b00} : {l_seq, 2'b00};

    // ---------------- update ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        tgt_d     = tgt_q;
        ctr_d     = ctr_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (upd_vld) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (upd_mispred) mis_cnt_d = mis_cnt_q + 32'd1;
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    tgt_d[u_idx] = upd_target[31:2];
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate over whatever occupied the slot, weakly taken.
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = upd_target[31:2];
                ctr_d[u_idx]   = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            tgt_q     <= tgt_d;
            ctr_q     <= ctr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_vld;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int tests = 0;
    int fails = 0;

    btb_predictor #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_vld(if_vld), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a 16-entry table indexed by word address mod 16,
    // tag is the PC divided by 64, counter kept as a plain integer 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_br, m_mis;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mis = 0;
    endfunction

    function automatic bit exp_taken(bit v, int unsigned pc);
        int i;
        i = (pc / 4) % 16;
        return !rst && v && m_valid[i] && m_tag[i] == pc / 64 && m_ctr[i] >= 2;
    endfunction

    function automatic int unsigned exp_next(bit v, int unsigned pc);
        if (exp_taken(v, pc)) return m_tgt[(pc / 4) % 16];
        return (pc & ~32'd3) + 4;
    endfunction

    function automatic void model_update();
        int i;
        int unsigned t;
        if (rst || !upd_vld) return;
        m_br++;
        if (upd_mispred) m_mis++;
        i = (upd_pc / 4) % 16;
        t = upd_pc / 64;
        if (m_valid[i] && m_tag[i] == t) begin
            if (upd_taken) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = upd_target & ~32'd3;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = upd_target & ~32'd3; m_ctr[i] = 2;
        end
    endfunction

    task automatic drive(input bit iv, input logic [31:0] ipc, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                         input bit um);
        if_vld = iv; if_pc = ipc; upd_vld = uv; upd_pc = upc;
        upd_taken = ut; upd_target = utgt; upd_mispred = um;
    endtask

    // One clock edge; model learns from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_taken got %0b exp 0", pred_taken); end
        tests++; if (pred_next_pc !== 32'h104) begin fails++; $display("FAIL reset_next got %h exp 00000104", pred_next_pc); end
        tests++; if (br_cnt !== 32'd0) begin fails++; $display("FAIL reset_br got %0d exp 0", br_cnt); end
        tests++; if (mispred_cnt !== 32'd0) begin fails++; $display("FAIL reset_mis got %0d exp 0", mispred_cnt); end
    endtask

    task automatic test_alloc();
        drive(0, 32'h100, 1, 32'h100, 1, 32'h200, 1);
        tick();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL alloc_taken got %0b exp 1", pred_taken); end
        tests++; if (pred_next_pc !== 32'h200) begin fails++; $display("FAIL alloc_next got %h exp 00000200", pred_next_pc); end
        tests++; if (br_cnt !== 32'd1) begin fails++; $display("FAIL alloc_br got %0d exp 1", br_cnt); end
        tests++; if (mispred_cnt !== 32'd1) begin fails++; $display("FAIL alloc_mis got %0d exp 1", mispred_cnt); end
    endtask

    task automatic test_saturate();
        // ctr 10 -> 01 -> 00 -> 00, then taken twice -> 01 -> 10
        bit          tk  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp [5] = '{32'h104, 32'h104, 32'h104, 32'h104, 32'h200};
        for (int k = 0; k < 5; k++) begin
            drive(0, 32'h100, 1, 32'h100, tk[k], 32'h200, 0);
            tick();
            drive(1, 32'h100, 0, 0, 0, 0, 0);
            #1;
            tests++;
            if (pred_next_pc !== exp[k]) begin
                fails++; $display("FAIL sat_step%0d got %h exp %h", k, pred_next_pc, exp[k]);
            end
        end
    endtask

    task automatic test_alias();
        drive(0, 0, 1, 32'h140, 1, 32'h500, 0);
        tick();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_next_pc !== 32'h104) begin fails++; $display("FAIL alias_old got %h exp 00000104", pred_next_pc); end
        if_pc = 32'h140;
        #1;
        tests++; if (pred_next_pc !== 32'h500) begin fails++; $display("FAIL alias_new got %h exp 00000500", pred_next_pc); end
    endtask

    task automatic test_same_cycle();
        drive(1, 32'h100, 1, 32'h100, 1, 32'h300, 0);
        #1;
        tests++; if (pred_next_pc !== 32'h104) begin fails++; $display("FAIL same_cyc_pre got %h exp 00000104", pred_next_pc); end
        tick();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_next_pc !== 32'h300) begin fails++; $display("FAIL same_cyc_post got %h exp 00000300", pred_next_pc); end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1, 32'h184, 1, 32'h400, 0);
        tick();
        drive(1, 32'h184, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_next_pc !== 32'h400) begin fails++; $display("FAIL arst_pre got %h exp 00000400", pred_next_pc); end
        // mid-cycle: update in flight, then reset asserted before the edge
        drive(1, 32'h184, 1, 32'h188, 1, 32'h600, 1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        tests++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h188) begin
            fails++; $display("FAIL arst_out got %0b/%h exp 0/00000188", pred_taken, pred_next_pc); end
        tests++; if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            fails++; $display("FAIL arst_cnt got %0d/%0d exp 0/0", br_cnt, mispred_cnt); end
        tick();
        rst = 1'b0;
        drive(1, 32'h188, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_next_pc !== 32'h18C) begin fails++; $display("FAIL arst_drop got %h exp 0000018c", pred_next_pc); end
        if_pc = 32'h184;
        #1;
        tests++; if (pred_next_pc !== 32'h188) begin fails++; $display("FAIL arst_clear got %h exp 00000188", pred_next_pc); end
    endtask

    task automatic test_wrap();
        drive(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_next_pc !== 32'h0) begin fails++; $display("FAIL wrap got %h exp 00000000", pred_next_pc); end
        // if_vld=0 on a trained taken entry still falls through
        drive(0, 0, 1, 32'h1C0, 1, 32'h700, 0);
        tick();
        drive(0, 32'h1C0, 0, 0, 0, 0, 0);
        #1;
        tests++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h1C4) begin
            fails++; $display("FAIL novld got %0b/%h exp 0/000001c4", pred_taken, pred_next_pc); end
    endtask

    task automatic test_random();
        logic [31:0] ipc, upc;
        for (int n = 0; n < 400; n++) begin
            ipc = 32'h1000 + 32'($urandom_range(1, 0)) * 32'h40 + 32'($urandom_range(7, 0)) * 4;
            upc = 32'h1000 + 32'($urandom_range(1, 0)) * 32'h40 + 32'($urandom_range(7, 0)) * 4;
            drive($urandom_range(3, 0) != 0, ipc, $urandom_range(1, 0) == 1, upc,
                  $urandom_range(2, 0) != 0, $urandom & 32'hFFFF_FFFC, $urandom_range(3, 0) == 0);
            #1;
            tests++;
            if (pred_taken !== exp_taken(if_vld, if_pc) || pred_next_pc !== exp_next(if_vld, if_pc)) begin
                fails++;
                $display("FAIL rand_pred n=%0d pc=%h got %0b/%h exp %0b/%h", n, if_pc,
                         pred_taken, pred_next_pc, exp_taken(if_vld, if_pc), exp_next(if_vld, if_pc));
            end
            tests++;
            if (br_cnt !== m_br || mispred_cnt !== m_mis) begin
                fails++;
                $display("FAIL rand_cnt n=%0d got %0d/%0d exp %0d/%0d", n, br_cnt, mispred_cnt, m_br, m_mis);
            end
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alloc();
        test_saturate();
        test_alias();
        test_same_cycle();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- It predicts the next fetch PC from the current fetch PC.
- The EXE-stage branch resolution drives it back: branch valid, taken result, resolved target and flush indication.
- It keeps 32-bit branch and misprediction event counters for performance monitoring.

Parameters:
- IDX_W, 4, index width; the BTB has 2^IDX_W entries.
- TAG_W, 32-IDX_W-2, tag width; PC[31:IDX_W+2]. Derived, not overridable.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- if_vld  input  1  fetch PC valid this cycle
- if_pc  input  32  current fetch PC, word aligned
- pred_taken  output  1  prediction: taken
- pred_next_pc  output  32  predicted next fetch PC
- upd_vld  input  1  a B-type branch resolved in EXE this cycle
- upd_pc  input  32  PC of the resolved branch (EXE PC)
- upd_taken  input  1  actual branch outcome
- upd_target  input  32  resolved taken target (EXE PC + offset)
- upd_mispred  input  1  EXE flush for this branch; sampled only when upd_vld=1
- br_cnt  output  32  count of resolved branches
- mispred_cnt  output  32  count of mispredicted branches

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (30 bits, PC[31:2]), ctr (2).
- Index = PC[IDX_W+1:2]. Tag = PC[31:IDX_W+2].
- Lookup is combinational in the same cycle as if_pc (zero latency):
  - hit = valid[idx] & (tag[idx]==if_pc tag) & if_vld.
  - pred_taken = hit & ctr[idx][1].
  - pred_next_pc = pred_taken ? {target[idx],2'b00} : if_pc+4. The +4 wraps modulo 2^32.
  - When if_vld=0: pred_taken=0 and pred_next_pc=if_pc+4.
- Update takes effect at the clock edge when upd_vld=1; it is visible to lookups from the next cycle.
- Update, hit case (valid and tag match on upd_pc):
  - ctr saturating: taken increments to max 11; not-taken decrements to min 00.
  - If taken, target <= upd_target[31:2].
- Update, miss with upd_taken=1: allocate the entry, overwriting any previous occupant. Set valid=1, tag, target, ctr=10 (weakly taken).
- Update, miss with upd_taken=0: no BTB change.
- Simultaneous lookup and update to the same index in the same cycle: the lookup returns the pre-update contents (no bypass).
- Counters:
  - br_cnt increments on each upd_vld.
  - mispred_cnt increments when upd_vld & upd_mispred.
  - Both wrap at 2^32.
  - upd_mispred with upd_vld=0 is ignored.
- Reset (asynchronous assert, at any time, including mid-update):
  - All valid bits=0, all ctr=01, tags and targets=0, br_cnt=0, mispred_cnt=0.
  - The in-flight update is discarded.
  - While rst=1: pred_taken=0 and pred_next_pc=if_pc+4.
- Recovery redirect on mispredict is the fetch unit's job; this block only predicts and learns.
- upd_target[1:0] and if_pc[1:0] are ignored.

Test Plan:
- Reset, then if_vld=1, if_pc=0x100 -> pred_taken=0, pred_next_pc=0x104; br_cnt=0, mispred_cnt=0.
- Update upd_pc=0x100, taken=1, target=0x200, mispred=1; next cycle if_pc=0x100 -> pred_taken=1, pred_next_pc=0x200; br_cnt=1, mispred_cnt=1.
- Three not-taken updates at 0x100 after allocation:
  - After the first: ctr=01, if_pc=0x100 -> pred_next_pc=0x104.
  - After the second: ctr=00.
  - After the third: ctr stays 00 (saturation).
  - Two taken updates then bring ctr to 10 -> predicted taken again.
- Aliasing with IDX_W=4: allocate 0x100->0x200, then taken update at 0x140 (same index, different tag) -> 0x100 now predicts 0x104; 0x140 predicts its own target.
- Same-cycle update of 0x100 (allocate, target 0x300) and lookup of 0x100 -> that cycle pred_next_pc=0x104; the following cycle 0x300.
- Assert rst asynchronously mid-cycle with upd_vld=1 -> outputs immediately return to the reset values; after deassert the entry is not present.
- Wrap: if_pc=0xFFFFFFFC on a miss -> pred_next_pc=0x00000000.
